// File: rtl/reg_write_arbiter_pkg.sv
// reg_write_arbiter_pkg
//   Shared definitions for the register-write arbiter: FSM state encoding,
//   default parameter values and a small index helper.
//   No ports (package).
package reg_write_arbiter_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_t;

   localparam int DEF_N_REQ = 4;
   localparam int DEF_N_REG = 4;
   localparam int DEF_DW    = 8;
   localparam int DEF_AW    = 2;

   // Next index in a ring of n entries (n-1 wraps to 0).
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if
//   Bundle between the requesting FSMs / register bank (master side) and the
//   arbiter (slave side).
//   req       requester -> arbiter, level request per requester
//   req_addr  requester -> arbiter, target register of requester i at [i*AW +: AW]
//   req_data  requester -> arbiter, write data of requester i at [i*DW +: DW]
//   gnt       arbiter -> requester, one-hot 1-cycle grant pulse
//   reg_we    arbiter -> bank, one-hot 1-cycle write enable
//   reg_data  arbiter -> bank, write data (holds last written value)
//   addr_err  arbiter -> requester, serviced request targeted a missing register
//   busy      arbiter -> requester, high during the write cycle
import reg_write_arbiter_pkg::*;

interface reg_write_arbiter_if #(
   parameter int N_REQ = DEF_N_REQ,
   parameter int N_REG = DEF_N_REG,
   parameter int DW    = DEF_DW,
   parameter int AW    = DEF_AW
);
   logic [N_REQ-1:0]    req;
   logic [N_REQ*AW-1:0] req_addr;
   logic [N_REQ*DW-1:0] req_data;
   logic [N_REQ-1:0]    gnt;
   logic [N_REG-1:0]    reg_we;
   logic [DW-1:0]       reg_data;
   logic                addr_err;
   logic                busy;

   modport master (
      output req, req_addr, req_data,
      input  gnt, reg_we, reg_data, addr_err, busy
   );

   modport slave (
      input  req, req_addr, req_data,
      output gnt, reg_we, reg_data, addr_err, busy
   );
endinterface

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: the first asserted request found when
//   scanning ptr, ptr+1, ... wrapping modulo N_REQ.
//   req        in   N_REQ  request vector
//   ptr        in   IW     highest-priority index this round (must be < N_REQ)
//   grant      out  N_REQ  one-hot winner (0 when no request)
//   grant_idx  out  IW     winner index (0 when no request)
//   valid      out  1      at least one request present
import reg_write_arbiter_pkg::*;

module rr_arbiter #(
   parameter int N_REQ = DEF_N_REQ,
   parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    grant_idx,
   output logic             valid
);

   // rot_idx[k] is the requester examined at scan position k.
   logic [IW-1:0] rot_idx [N_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_rot
         assign rot_idx[gi] = IW'((int'(ptr) + gi) % N_REQ);
      end
   endgenerate

   // Scan from the far end back to position 0 so the closest request to ptr
   // is the last (and therefore winning) assignment.
   always_comb begin
      grant_idx = '0;
      valid     = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[rot_idx[k]]) begin
            grant_idx = rot_idx[k];
            valid     = 1'b1;
         end
      end
   end

   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
         assign grant[gi] = valid && (grant_idx == IW'(gi));
      end
   endgenerate

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Shares a bank of N_REG write-enabled registers among N_REQ requesters.
//   Round-robin arbitration, one register write per grant, one write every
//   two cycles at most. All outputs are registered.
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-high
//   bus    slave modport of reg_write_arbiter_if (req/req_addr/req_data in;
//          gnt/reg_we/reg_data/addr_err/busy out)
import reg_write_arbiter_pkg::*;

module reg_write_arbiter #(
   parameter int N_REQ = DEF_N_REQ,
   parameter int N_REG = DEF_N_REG,
   parameter int DW    = DEF_DW,
   parameter int AW    = DEF_AW
) (
   input  logic               clk,
   input  logic               reset,
   reg_write_arbiter_if.slave bus
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t           state_reg, state_next;
   logic [IW-1:0]    rr_ptr_reg;
   logic [IW-1:0]    win_idx_reg;

   logic [N_REQ-1:0] gnt_reg,      gnt_next;
   logic [N_REG-1:0] reg_we_reg,   reg_we_next;
   logic [DW-1:0]    reg_data_reg, reg_data_next;
   logic             addr_err_reg, addr_err_next;
   logic             busy_reg,     busy_next;

   logic [N_REQ-1:0] arb_grant;
   logic [IW-1:0]    arb_idx;
   logic             arb_valid;

   logic [AW-1:0]    addr_arr [N_REQ];
   logic [DW-1:0]    data_arr [N_REQ];
   logic [AW-1:0]    sel_addr;
   logic [DW-1:0]    sel_data;
   logic             addr_ok;
   logic [N_REG-1:0] dec_we;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr_arbiter (
      .req       (bus.req),
      .ptr       (rr_ptr_reg),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .valid     (arb_valid)
   );

   // Unpack the flat address/data buses into per-requester slices.
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign addr_arr[gi] = bus.req_addr[gi*AW +: AW];
         assign data_arr[gi] = bus.req_data[gi*DW +: DW];
      end
   endgenerate

   assign sel_addr = addr_arr[arb_idx];
   assign sel_data = data_arr[arb_idx];
   assign addr_ok  = (int'(sel_addr) < N_REG);

   // One-hot address decode onto the implemented registers only.
   generate
      for (gi = 0; gi < N_REG; gi++) begin : g_decode
         assign dec_we[gi] = (sel_addr == AW'(gi));
      end
   endgenerate

   // State register plus the winner latch and round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         rr_ptr_reg  <= '0;
         win_idx_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_IDLE && arb_valid) begin
            win_idx_reg <= arb_idx;
         end
         // Pointer moves only when a grant completes.
         if (state_reg == ST_WRITE) begin
            rr_ptr_reg <= IW'(wrap_inc(int'(win_idx_reg), N_REQ));
         end
      end
   end

   // Next-state logic: a sampled request opens exactly one write cycle.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (arb_valid) state_next = ST_WRITE;
         ST_WRITE: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Output logic. The outputs seen during WRITE are loaded on the edge that
   // leaves IDLE, so the output registers double as the latched address and
   // data; later changes on req_addr/req_data cannot disturb the write.
   always_comb begin
      gnt_next      = '0;
      reg_we_next   = '0;
      reg_data_next = reg_data_reg;
      addr_err_next = 1'b0;
      busy_next     = 1'b0;
      if (state_reg == ST_IDLE && arb_valid) begin
         gnt_next  = arb_grant;
         busy_next = 1'b1;
         if (addr_ok) begin
            reg_we_next   = dec_we;
            reg_data_next = sel_data;
         end else begin
            addr_err_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_reg      <= '0;
         reg_we_reg   <= '0;
         reg_data_reg <= '0;
         addr_err_reg <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         gnt_reg      <= gnt_next;
         reg_we_reg   <= reg_we_next;
         reg_data_reg <= reg_data_next;
         addr_err_reg <= addr_err_next;
         busy_reg     <= busy_next;
      end
   end

   assign bus.gnt      = gnt_reg;
   assign bus.reg_we   = reg_we_reg;
   assign bus.reg_data = reg_data_reg;
   assign bus.addr_err = addr_err_reg;
   assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter
//   Two arbiters (4 registers and 3 registers) share one stimulus stream. A
//   behavioural model predicts outputs and bank contents; a negedge process
//   compares every cycle, and directed literal checks pin the model.
import reg_write_arbiter_pkg::*;

module tb_reg_write_arbiter;

   localparam int NQ = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        bank_clr;
   logic [3:0]  req;
   logic [7:0]  req_addr;
   logic [31:0] req_data;
   bit          chk_en = 1'b0;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   reg_write_arbiter_if #(.N_REQ(4), .N_REG(4), .DW(8), .AW(2)) ifa ();
   reg_write_arbiter_if #(.N_REQ(4), .N_REG(3), .DW(8), .AW(2)) ifb ();

   assign ifa.req      = req;
   assign ifa.req_addr = req_addr;
   assign ifa.req_data = req_data;
   assign ifb.req      = req;
   assign ifb.req_addr = req_addr;
   assign ifb.req_data = req_data;

   reg_write_arbiter #(.N_REQ(4), .N_REG(4), .DW(8), .AW(2)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   reg_write_arbiter #(.N_REQ(4), .N_REG(3), .DW(8), .AW(2)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   // Uniform views of both DUTs.
   logic [3:0] a_gnt [2];
   logic [3:0] a_we  [2];
   logic [7:0] a_data[2];
   logic       a_err [2];
   logic       a_busy[2];

   assign a_gnt[0]  = ifa.gnt;
   assign a_gnt[1]  = ifb.gnt;
   assign a_we[0]   = ifa.reg_we;
   assign a_we[1]   = {1'b0, ifb.reg_we};
   assign a_data[0] = ifa.reg_data;
   assign a_data[1] = ifb.reg_data;
   assign a_err[0]  = ifa.addr_err;
   assign a_err[1]  = ifb.addr_err;
   assign a_busy[0] = ifa.busy;
   assign a_busy[1] = ifb.busy;

   // Register banks driven by the DUTs.
   logic [7:0] d_bank [2][4];
   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         for (int j = 0; j < 4; j++) begin
            if (bank_clr) d_bank[m][j] <= 8'h00;
            else if (!reset && a_we[m][j]) d_bank[m][j] <= a_data[m];
         end
      end
   end

   // Behavioural model state and expectations.
   int         m_ptr [2];
   bit         m_inw [2];
   int         m_win [2];
   int         m_addr[2];
   logic [7:0] m_data[2];
   logic [3:0] e_gnt [2];
   logic [3:0] e_we  [2];
   logic [7:0] e_data[2];
   logic       e_err [2];
   logic       e_busy[2];
   logic [7:0] m_bank[2][4];

   function automatic int nreg_of(input int m);
      return (m == 0) ? 4 : 3;
   endfunction

   // Called exactly at each rising edge, with the inputs as sampled there.
   task automatic model_update();
      int w;
      for (int m = 0; m < 2; m++) begin
         if (bank_clr) begin
            for (int j = 0; j < 4; j++) m_bank[m][j] = 8'h00;
         end
         if (reset) begin
            m_inw[m]  = 1'b0;
            m_ptr[m]  = 0;
            e_gnt[m]  = '0;
            e_we[m]   = '0;
            e_err[m]  = 1'b0;
            e_busy[m] = 1'b0;
            e_data[m] = 8'h00;
         end else if (m_inw[m]) begin
            if (m_addr[m] < nreg_of(m)) m_bank[m][m_addr[m]] = m_data[m];
            m_ptr[m]  = (m_win[m] + 1) % NQ;
            m_inw[m]  = 1'b0;
            e_gnt[m]  = '0;
            e_we[m]   = '0;
            e_err[m]  = 1'b0;
            e_busy[m] = 1'b0;
         end else if (req != 4'b0000) begin
            w = -1;
            for (int k = 0; k < NQ; k++) begin
               if (w < 0 && req[(m_ptr[m] + k) % NQ]) w = (m_ptr[m] + k) % NQ;
            end
            m_win[m]  = w;
            m_addr[m] = int'(req_addr[w*2 +: 2]);
            m_data[m] = req_data[w*8 +: 8];
            m_inw[m]  = 1'b1;
            e_gnt[m]  = 4'(1 << w);
            e_busy[m] = 1'b1;
            e_we[m]   = '0;
            e_err[m]  = 1'b0;
            if (m_addr[m] < nreg_of(m)) begin
               e_we[m]   = 4'(1 << m_addr[m]);
               e_data[m] = m_data[m];
            end else begin
               e_err[m] = 1'b1;
            end
         end else begin
            e_gnt[m]  = '0;
            e_we[m]   = '0;
            e_err[m]  = 1'b0;
            e_busy[m] = 1'b0;
         end
      end
   endtask

   task automatic check(input string name, input int m, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d: got %0h, expected %0h", name, m, act, exp);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int m = 0; m < 2; m++) begin
            check("gnt",      m, 32'(a_gnt[m]),  32'(e_gnt[m]));
            check("reg_we",   m, 32'(a_we[m]),   32'(e_we[m]));
            check("reg_data", m, 32'(a_data[m]), 32'(e_data[m]));
            check("addr_err", m, 32'(a_err[m]),  32'(e_err[m]));
            check("busy",     m, 32'(a_busy[m]), 32'(e_busy[m]));
            for (int j = 0; j < 4; j++) begin
               check("bank", m, 32'(d_bank[m][j]), 32'(m_bank[m][j]));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   int got_id [$];
   int got_cyc[$];
   int hold   [4];
   int gid;
   int exp_id [5] = '{0, 1, 2, 3, 0};
   int exp_cyc[5] = '{1, 3, 5, 7, 9};

   initial begin
      reset    = 1'b1;
      bank_clr = 1'b1;
      req      = 4'b1111;
      req_addr = 8'h00;
      req_data = 32'h0;

      // 1. Reset held two cycles with all requests high.
      step();
      chk_en = 1'b1;
      check("rst_gnt",  0, 32'(ifa.gnt),      32'h0);
      check("rst_busy", 0, 32'(ifa.busy),     32'h0);
      step();
      check("rst_we",   0, 32'(ifa.reg_we),   32'h0);
      check("rst_data", 0, 32'(ifa.reg_data), 32'h0);
      reset    = 1'b0;
      bank_clr = 1'b0;
      req      = 4'b0000;

      // 3. Fairness: each requester drops after its grant, re-raises later.
      req_addr = {2'd3, 2'd2, 2'd1, 2'd0};
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      req      = 4'b1111;
      for (int i = 0; i < 4; i++) hold[i] = 0;
      for (int c = 1; c <= 9; c++) begin
         step();
         for (int i = 0; i < 4; i++) begin
            if (hold[i] > 0) begin
               hold[i]--;
               if (hold[i] == 0) req[i] = 1'b1;
            end
         end
         if (ifa.gnt != 4'b0000) begin
            gid = 0;
            for (int i = 0; i < 4; i++) if (ifa.gnt[i]) gid = i;
            got_id.push_back(gid);
            got_cyc.push_back(c);
            req[gid] = 1'b0;
            hold[gid] = 2;
         end
      end
      req = 4'b0000;
      step();
      check("fair_count", 0, 32'(got_id.size()), 32'd5);
      for (int k = 0; k < 5 && k < got_id.size(); k++) begin
         check("fair_order", 0, 32'(got_id[k]),  32'(exp_id[k]));
         check("fair_cycle", 0, 32'(got_cyc[k]), 32'(exp_cyc[k]));
      end

      // 2. Single write: requester 2 -> register 3, data A5.
      req_addr[5:4]   = 2'd3;
      req_data[23:16] = 8'hA5;
      req = 4'b0100;
      step();
      check("wr_gnt",  0, 32'(ifa.gnt),      32'h4);
      check("wr_we",   0, 32'(ifa.reg_we),   32'h8);
      check("wr_data", 0, 32'(ifa.reg_data), 32'hA5);
      check("wr_busy", 0, 32'(ifa.busy),     32'h1);
      check("wr_err3", 1, 32'(ifb.addr_err), 32'h1);
      req = 4'b0000;
      step();
      check("wr_bank", 0, 32'(d_bank[0][3]), 32'hA5);
      check("wr_idle", 0, 32'(ifa.gnt),      32'h0);

      // 4. Wrap: pointer at 3, requesters 3 and 0.
      req_addr[7:6]   = 2'd2;
      req_data[31:24] = 8'h77;
      req_addr[1:0]   = 2'd1;
      req_data[7:0]   = 8'h66;
      req = 4'b1001;
      step();
      check("wrap_gnt3", 0, 32'(ifa.gnt),    32'h8);
      check("wrap_we3",  0, 32'(ifa.reg_we), 32'h4);
      req = 4'b0001;
      step();
      step();
      check("wrap_gnt0", 0, 32'(ifa.gnt),      32'h1);
      check("wrap_data", 0, 32'(ifa.reg_data), 32'h66);
      req = 4'b0000;
      step();

      // 5. Bad address on the 3-register bank.
      req_addr[3:2]  = 2'd3;
      req_data[15:8] = 8'h5A;
      req = 4'b0010;
      step();
      check("bad_gnt", 1, 32'(ifb.gnt),      32'h2);
      check("bad_err", 1, 32'(ifb.addr_err), 32'h1);
      check("bad_we",  1, 32'(ifb.reg_we),   32'h0);
      check("ok_we",   0, 32'(ifa.reg_we),   32'h8);
      req = 4'b0000;
      step();
      check("bad_bank", 1, 32'(d_bank[1][3]), 32'h0);
      check("ok_bank",  0, 32'(d_bank[0][3]), 32'h5A);

      // 6. Reset over the edge that would start requester 0's write.
      req_addr[1:0] = 2'd1;
      req_data[7:0] = 8'h3C;
      req   = 4'b0001;
      reset = 1'b1;
      step();
      check("rmid_gnt", 0, 32'(ifa.gnt),    32'h0);
      check("rmid_we",  0, 32'(ifa.reg_we), 32'h0);
      step();
      check("rmid_busy", 0, 32'(ifa.busy),    32'h0);
      check("rmid_bank", 0, 32'(d_bank[0][1]), 32'h66);
      reset = 1'b0;
      step();
      check("rerun_gnt",  0, 32'(ifa.gnt),      32'h1);
      check("rerun_we",   0, 32'(ifa.reg_we),   32'h2);
      check("rerun_data", 0, 32'(ifa.reg_data), 32'h3C);
      req = 4'b0000;
      step();
      check("rerun_bank", 0, 32'(d_bank[0][1]), 32'h3C);
      step();
      step();
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
